// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared CPU constants and types.
//   ADDR_W        : PC / instruction-memory address width
//   INSTR_W       : instruction word width
//   OPC_W         : opcode field width (top bits of the instruction)
//   HALT_OPCODE   : opcode that stops instruction fetch
//   fetch_state_t : fetch unit control state (FETCH / HALTED)
package cpu_pkg;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 24;
  localparam int OPC_W   = 4;
  localparam logic [OPC_W-1:0] HALT_OPCODE = 4'hF;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage. Holds the PC, addresses the instruction memory
// combinationally, registers the returned word and offers it to decode over
// a valid/ready handshake. A taken branch (redirect) reloads the PC and
// flushes the output register; a HALT opcode stops fetch until redirected.
// Ports:
//   clk             : clock, rising edge
//   rst_n           : asynchronous active-low reset
//   imem_addr       : address to instruction memory (the PC)
//   imem_data       : instruction returned for imem_addr
//   out_valid       : output register holds an instruction for decode
//   out_ready       : decode accepts this cycle
//   out_instr       : registered instruction
//   out_pc          : address the registered instruction came from
//   redirect_valid  : load redirect_target into the PC and flush
//   redirect_target : new PC
//   halted          : fetch stopped on a HALT instruction
module fetch_unit #(
  parameter int ADDR_W  = cpu_pkg::ADDR_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int OPC_W   = cpu_pkg::OPC_W,
  parameter logic [OPC_W-1:0] HALT_OPCODE = cpu_pkg::HALT_OPCODE,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               halted
);
  import cpu_pkg::*;

  fetch_state_t        state;
  logic [ADDR_W-1:0]   pc_p0;
  logic                vld_p1;
  logic [INSTR_W-1:0]  instr_p1;
  logic [ADDR_W-1:0]   pc_p1;
  logic                load;
  logic                is_halt;

  // Capture whenever the output slot is free or being drained; a redirect
  // in the same cycle wins and suppresses the capture.
  assign load    = (state == FETCH) && (!vld_p1 || out_ready) && !redirect_valid;
  assign is_halt = (imem_data[INSTR_W-1 -: OPC_W] == HALT_OPCODE);

  // Stage p0: PC drives instruction memory directly
  assign imem_addr = pc_p0;

  // Stage p1: registered instruction handed to decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc_p0    <= RESET_PC;
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
    end else if (redirect_valid) begin
      // Flush: any handshake this cycle is discarded.
      state  <= FETCH;
      pc_p0  <= redirect_target;
      vld_p1 <= 1'b0;
    end else if (load) begin
      instr_p1 <= imem_data;
      pc_p1    <= pc_p0;
      vld_p1   <= 1'b1;
      if (is_halt) begin
        // PC stays on the HALT word so a later inspection sees where fetch stopped.
        state <= HALTED;
      end else begin
        pc_p0 <= pc_p0 + 1'b1;
      end
    end else if (state == HALTED && vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_instr = instr_p1;
  assign out_pc    = pc_p1;
  // state is a register, so halted rises on the same edge that captures HALT.
  assign halted    = (state == HALTED);

endmodule
